ppb_pad_responder: RTL and testbench
====================================

# ppb_pad_responder

Digital-pad protocol engine on the device side of the Playstation Parallel Bus (PPB). It sits behind `psx_device_port` and consumes each received command byte. For every byte it decides whether to ACK and which reply byte to present next, so the port emulates a standard PSX digital controller (optionally an analog one) whose button state comes from fabric logic. Per packet it sequences address check, ID, 0x5A header and data bytes, and snapshots the button inputs so one packet is always self-consistent.

## Interface
- Parameters
- `PAD_ADDRESS`, 8'h01: first command byte that selects this device.
- `POLL_CMD`, 8'h42: second command byte that requests a poll.
- Ports
- `clk` input 1: system clock.
- `reset` input 1: synchronous, active-high reset.
- `PPB_packet_reset` input 1: HIGH while the device is deselected. It is sampled synchronously and has the same effect as `reset`.
- `PPB_command` input 8: received command byte. Valid when `PPB_command_strobe` is HIGH.
- `PPB_command_strobe` input 1: one-cycle pulse when a command byte completes.
- `PPB_reply` output 8: reply byte for the next byte slot. Registered.
- `PPB_reply_ready` input 1: one-cycle pulse when the port latches `PPB_reply`. Used only for the consumed-byte check.
- `PPB_ack_strobe` output 1: one-cycle pulse requesting ACK for the byte just received.
- `buttons` input 16: live button state, active-low, bit0 = SELECT … bit15 = SQUARE.
- `sticks` input 32: {LY, LX, RY, RX}, 8 bits each. Used only with `PPB_PAD_ANALOG_EN`.
- `poll_strobe` output 1: one-cycle pulse when a complete poll packet has finished.
- `reply_underrun` output 1: sticky flag, cleared only by `reset`.

## Operation
- States: IDLE, ID, HDR, DATA, DONE, IGNORE. A 4-bit counter `data_idx` tracks position in DATA.
- Reset or `PPB_packet_reset`:
  - Next state is IDLE.
  - `PPB_reply` = 8'hFF, `PPB_ack_strobe` = 0, `poll_strobe` = 0, `data_idx` = 0.
  - The button/stick snapshot is left unchanged.
- All transitions below occur only on `PPB_command_strobe`.
- IDLE, byte 0 (byte 0 reply is 8'hFF):
  - If `PPB_command` == `PAD_ADDRESS`: ACK, set reply to the ID byte, go to ID.
  - Otherwise: go to IGNORE.
- ID, byte 1:
  - If `PPB_command` == `POLL_CMD`: ACK, snapshot `buttons` (and `sticks`), set reply to 8'h5A, go to HDR.
  - Otherwise: reply 8'hFF, go to IGNORE.
- HDR, byte 2: ACK, set reply to snapshot[7:0], set `data_idx` = 1, go to DATA.
- DATA, bytes 3..N-1:
  - Reply sequence: snapshot[15:8], then (analog only) RX, RY, LX, LY.
  - ACK every byte except the final one of the packet.
  - On the final byte: no ACK, reply 8'hFF, pulse `poll_strobe`, go to DONE.
- DONE and IGNORE: absorb every further strobe with no ACK, reply held at 8'hFF. Only a reset leaves these states.
- Final data byte position: N = 5 for a digital pad, N = 9 for an analog pad. `data_idx` never exceeds N−3 and never wraps.
- `reply_underrun`: set if `PPB_reply_ready` pulses in the same cycle that `PPB_reply` changes.
- Simultaneous events:
  - `reset` or `PPB_packet_reset` with `PPB_command_strobe`: reset wins, no ACK.
  - Reset mid-packet: the packet is aborted and no `poll_strobe` is generated.

## Timing
- `PPB_ack_strobe`, `poll_strobe` and the new `PPB_reply` are all valid in the cycle after `PPB_command_strobe` (latency 1), for exactly one cycle for the strobes.
- `PPB_reply` stays stable until the next `PPB_command_strobe` or reset. At 25 MHz this gives ≥1 µs of margin before the next byte's first falling PSX clock edge.
- The snapshot is taken in the same cycle that byte 1 is accepted. Inputs changing afterwards do not affect the current packet.
- No combinational path from any input to any output.

## Configuration
- `PPB_PAD_ANALOG_EN` defined:
  - ID byte is 8'h73 and packets are 9 bytes.
  - The last four replies are `sticks` bytes RX, RY, LX, LY.
- `PPB_PAD_ANALOG_EN` undefined:
  - ID byte is 8'h41 and packets are 5 bytes.
  - `sticks` is ignored, and the DATA counter logic synthesises to 1 bit.

## Test plan
- Digital poll: reset → `PPB_reply` = FF. Send 01, 42, 00, 00, 00 with `buttons` = 16'hFFFE.
  - Replies FF, 41, 5A, FE, FF.
  - ACK pulses after bytes 0–3 only.
  - `poll_strobe` once, after byte 4.
- Wrong address: send 81, 42, 00.
  - No ACK at all, `PPB_reply` stays FF, no `poll_strobe`.
- Snapshot: change `buttons` from 16'hFFFF to 16'h0000 after byte 2 of a poll.
  - Bytes 3 and 4 reply FF, FF.
  - The next packet replies 00, 00.
- Mid-packet deselect: pulse `PPB_packet_reset` after byte 2, then run a full poll.
  - No `poll_strobe` for the aborted packet.
  - The second packet is correct, with a 41 ID.
- Analog build (`PPB_PAD_ANALOG_EN`): `sticks` = 32'h11223344, 9-byte poll.
  - Replies FF, 73, 5A, b0, b1, 44, 33, 22, 11.
  - 8 ACKs; bytes 9 and 10 are ignored.
- Strobe collision: assert `PPB_command_strobe` and `reset` together.
  - No ACK, state IDLE, `PPB_reply` = FF.

Source files
------------

// File: rtl/ppb_pad_responder.sv
// PSX pad protocol engine behind the PPB device port: per-byte ACK and reply sequencing.
// Define PPB_PAD_ANALOG_EN for the analog pad (ID 8'h73, 9-byte packets with stick bytes).
module ppb_pad_responder #(
    parameter logic [7:0] PAD_ADDRESS = 8'h01,
    parameter logic [7:0] POLL_CMD    = 8'h42
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PPB_packet_reset,
    input  logic [7:0]  PPB_command,
    input  logic        PPB_command_strobe,
    output logic [7:0]  PPB_reply,
    input  logic        PPB_reply_ready,
    output logic        PPB_ack_strobe,
    input  logic [15:0] buttons,
    input  logic [31:0] sticks,
    output logic        poll_strobe,
    output logic        reply_underrun
);

`ifdef PPB_PAD_ANALOG_EN
    localparam logic [7:0] ID_BYTE  = 8'h73;
    localparam logic [3:0] LAST_IDX = 4'd6;
`else
    localparam logic [7:0] ID_BYTE  = 8'h41;
    localparam logic [3:0] LAST_IDX = 4'd2;
`endif

    typedef enum logic [2:0] {IDLE, ID, HDR, DATA, DONE, IGNORE} state_t;

    state_t      state, state_n;
    logic [3:0]  data_idx, idx_n;
    logic [7:0]  reply_n, data_byte;
    logic        ack_n, poll_n, snap_en, clr;
    logic [15:0] snap_btn;

    assign clr = reset | PPB_packet_reset;

`ifdef PPB_PAD_ANALOG_EN
    logic [31:0] snap_stk;

    always_ff @(posedge clk)
        if (snap_en && !clr) snap_stk <= sticks;

    always_comb begin
        case (data_idx)
            4'd1:    data_byte = snap_btn[15:8];
            4'd2:    data_byte = snap_stk[7:0];
            4'd3:    data_byte = snap_stk[15:8];
            4'd4:    data_byte = snap_stk[23:16];
            4'd5:    data_byte = snap_stk[31:24];
            default: data_byte = 8'hFF;
        endcase
    end
`else
    logic unused_sticks;
    assign unused_sticks = ^sticks;
    // Only one non-final data byte exists in a digital packet.
    assign data_byte = snap_btn[15:8];
`endif

    always_comb begin
        state_n = state;
        reply_n = PPB_reply;
        ack_n   = 1'b0;
        poll_n  = 1'b0;
        idx_n   = data_idx;
        snap_en = 1'b0;
        if (PPB_command_strobe) begin
            case (state)
                IDLE: begin
                    if (PPB_command == PAD_ADDRESS) begin
                        ack_n   = 1'b1;
                        reply_n = ID_BYTE;
                        state_n = ID;
                    end else begin
                        reply_n = 8'hFF;
                        state_n = IGNORE;
                    end
                end
                ID: begin
                    if (PPB_command == POLL_CMD) begin
                        ack_n   = 1'b1;
                        snap_en = 1'b1;
                        reply_n = 8'h5A;
                        state_n = HDR;
                    end else begin
                        reply_n = 8'hFF;
                        state_n = IGNORE;
                    end
                end
                HDR: begin
                    ack_n   = 1'b1;
                    reply_n = snap_btn[7:0];
                    idx_n   = 4'd1;
                    state_n = DATA;
                end
                DATA: begin
                    if (data_idx == LAST_IDX) begin
                        reply_n = 8'hFF;
                        poll_n  = 1'b1;
                        state_n = DONE;
                    end else begin
                        ack_n   = 1'b1;
                        reply_n = data_byte;
                        idx_n   = data_idx + 4'd1;
                    end
                end
                default: reply_n = 8'hFF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state          <= IDLE;
            PPB_reply      <= 8'hFF;
            PPB_ack_strobe <= 1'b0;
            poll_strobe    <= 1'b0;
            data_idx       <= 4'd0;
        end else begin
            state          <= state_n;
            PPB_reply      <= reply_n;
            PPB_ack_strobe <= ack_n;
            poll_strobe    <= poll_n;
            data_idx       <= idx_n;
        end
    end

    // Snapshot survives resets so a deselect never corrupts the held button state.
    always_ff @(posedge clk)
        if (snap_en && !clr) snap_btn <= buttons;

    always_ff @(posedge clk) begin
        if (reset)
            reply_underrun <= 1'b0;
        else if (PPB_reply_ready && ((PPB_packet_reset ? 8'hFF : reply_n) != PPB_reply))
            reply_underrun <= 1'b1;
    end

endmodule

// File: tb/tb_ppb_pad_responder.sv
// Directed bench for ppb_pad_responder: poll sequencing, snapshot, aborts and collisions.
module tb_ppb_pad_responder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        PPB_packet_reset = 1'b0;
    logic [7:0]  PPB_command = 8'h00;
    logic        PPB_command_strobe = 1'b0;
    logic [7:0]  PPB_reply;
    logic        PPB_reply_ready = 1'b0;
    logic        PPB_ack_strobe;
    logic [15:0] buttons = 16'hFFFF;
    logic [31:0] sticks = 32'h0;
    logic        poll_strobe;
    logic        reply_underrun;

    int checks = 0;
    int passes = 0;

    ppb_pad_responder dut (
        .clk(clk), .reset(reset), .PPB_packet_reset(PPB_packet_reset),
        .PPB_command(PPB_command), .PPB_command_strobe(PPB_command_strobe),
        .PPB_reply(PPB_reply), .PPB_reply_ready(PPB_reply_ready),
        .PPB_ack_strobe(PPB_ack_strobe), .buttons(buttons), .sticks(sticks),
        .poll_strobe(poll_strobe), .reply_underrun(reply_underrun)
    );

    always #5 clk = ~clk;

    // Strobe one byte; outputs sampled on the falling edge after the capturing edge.
    task automatic send(input logic [7:0] b, output logic ack, output logic [7:0] rep,
                        output logic poll);
        @(negedge clk);
        PPB_command = b;
        PPB_command_strobe = 1'b1;
        @(negedge clk);
        PPB_command_strobe = 1'b0;
        ack  = PPB_ack_strobe;
        rep  = PPB_reply;
        poll = poll_strobe;
    endtask

    task automatic deselect();
        @(negedge clk);
        PPB_packet_reset = 1'b1;
        @(negedge clk);
        PPB_packet_reset = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checks++; if (PPB_reply !== 8'hFF) $display("FAIL reset_reply got %h exp ff", PPB_reply); else passes++;
        checks++; if (PPB_ack_strobe !== 1'b0) $display("FAIL reset_ack got %b exp 0", PPB_ack_strobe); else passes++;
        checks++; if (poll_strobe !== 1'b0) $display("FAIL reset_poll got %b exp 0", poll_strobe); else passes++;
        checks++; if (reply_underrun !== 1'b0) $display("FAIL reset_underrun got %b exp 0", reply_underrun); else passes++;
    endtask

    task automatic test_wrong_address();
        logic a, p; logic [7:0] r;
        logic [7:0] cmds [3];
        cmds = '{8'h81, 8'h42, 8'h00};
        deselect();
        for (int i = 0; i < 3; i++) begin
            send(cmds[i], a, r, p);
            checks++; if (a !== 1'b0) $display("FAIL wrongaddr_ack[%0d] got %b exp 0", i, a); else passes++;
            checks++; if (r !== 8'hFF) $display("FAIL wrongaddr_reply[%0d] got %h exp ff", i, r); else passes++;
            checks++; if (p !== 1'b0) $display("FAIL wrongaddr_poll[%0d] got %b exp 0", i, p); else passes++;
        end
    endtask

    task automatic test_collision();
        logic a, p; logic [7:0] r;
        deselect();
        @(negedge clk);
        PPB_command = 8'h01;
        PPB_command_strobe = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        PPB_command_strobe = 1'b0;
        reset = 1'b0;
        checks++; if (PPB_ack_strobe !== 1'b0) $display("FAIL collision_ack got %b exp 0", PPB_ack_strobe); else passes++;
        checks++; if (PPB_reply !== 8'hFF) $display("FAIL collision_reply got %h exp ff", PPB_reply); else passes++;
        // Still in IDLE: a correct address is accepted next.
        send(8'h01, a, r, p);
        checks++; if (a !== 1'b1) $display("FAIL collision_idle_ack got %b exp 1", a); else passes++;
`ifdef PPB_PAD_ANALOG_EN
        checks++; if (r !== 8'h73) $display("FAIL collision_idle_id got %h exp 73", r); else passes++;
`else
        checks++; if (r !== 8'h41) $display("FAIL collision_idle_id got %h exp 41", r); else passes++;
`endif
    endtask

    task automatic test_underrun();
        deselect();
        @(negedge clk);
        PPB_command = 8'h01;
        PPB_command_strobe = 1'b1;
        PPB_reply_ready = 1'b1;
        @(negedge clk);
        PPB_command_strobe = 1'b0;
        PPB_reply_ready = 1'b0;
        checks++; if (reply_underrun !== 1'b1) $display("FAIL underrun_set got %b exp 1", reply_underrun); else passes++;
        deselect();
        checks++; if (reply_underrun !== 1'b1) $display("FAIL underrun_sticky got %b exp 1", reply_underrun); else passes++;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        checks++; if (reply_underrun !== 1'b0) $display("FAIL underrun_clear got %b exp 0", reply_underrun); else passes++;
    endtask

`ifndef PPB_PAD_ANALOG_EN
    task automatic test_digital_poll();
        logic a, p; logic [7:0] r;
        logic [7:0] cmds [6];
        logic [7:0] exp_r [6];
        logic       exp_a [6];
        logic       exp_p [6];
        cmds  = '{8'h01, 8'h42, 8'h00, 8'h00, 8'h00, 8'h00};
        exp_r = '{8'h41, 8'h5A, 8'hFE, 8'hFF, 8'hFF, 8'hFF};
        exp_a = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        exp_p = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        buttons = 16'hFFFE;
        for (int i = 0; i < 6; i++) begin
            send(cmds[i], a, r, p);
            checks++; if (r !== exp_r[i]) $display("FAIL poll_reply[%0d] got %h exp %h", i, r, exp_r[i]); else passes++;
            checks++; if (a !== exp_a[i]) $display("FAIL poll_ack[%0d] got %b exp %b", i, a, exp_a[i]); else passes++;
            checks++; if (p !== exp_p[i]) $display("FAIL poll_strobe[%0d] got %b exp %b", i, p, exp_p[i]); else passes++;
        end
        @(negedge clk);
        checks++; if (poll_strobe !== 1'b0) $display("FAIL poll_strobe_width got %b exp 0", poll_strobe); else passes++;
    endtask

    task automatic test_snapshot();
        logic a, p; logic [7:0] r;
        deselect();
        buttons = 16'hFFFF;
        send(8'h01, a, r, p);
        send(8'h42, a, r, p);
        send(8'h00, a, r, p);
        buttons = 16'h0000;
        checks++; if (r !== 8'hFF) $display("FAIL snap_byte3 got %h exp ff", r); else passes++;
        send(8'h00, a, r, p);
        checks++; if (r !== 8'hFF) $display("FAIL snap_byte4 got %h exp ff", r); else passes++;
        send(8'h00, a, r, p);
        deselect();
        send(8'h01, a, r, p);
        send(8'h42, a, r, p);
        send(8'h00, a, r, p);
        checks++; if (r !== 8'h00) $display("FAIL snap_next_byte3 got %h exp 00", r); else passes++;
        send(8'h00, a, r, p);
        checks++; if (r !== 8'h00) $display("FAIL snap_next_byte4 got %h exp 00", r); else passes++;
    endtask

    task automatic test_mid_deselect();
        logic a, p; logic [7:0] r;
        int polls;
        polls = 0;
        deselect();
        buttons = 16'hA55A;
        send(8'h01, a, r, p); polls += int'(p);
        send(8'h42, a, r, p); polls += int'(p);
        send(8'h00, a, r, p); polls += int'(p);
        deselect();
        polls += int'(poll_strobe);
        checks++; if (PPB_reply !== 8'hFF) $display("FAIL abort_reply got %h exp ff", PPB_reply); else passes++;
        checks++; if (polls !== 0) $display("FAIL abort_poll got %0d exp 0", polls); else passes++;
        send(8'h01, a, r, p);
        checks++; if (r !== 8'h41) $display("FAIL abort_next_id got %h exp 41", r); else passes++;
        send(8'h42, a, r, p);
        send(8'h00, a, r, p);
        checks++; if (r !== 8'h5A) $display("FAIL abort_next_b0 got %h exp 5a", r); else passes++;
        send(8'h00, a, r, p);
        checks++; if (r !== 8'hA5) $display("FAIL abort_next_b1 got %h exp a5", r); else passes++;
        send(8'h00, a, r, p);
        checks++; if (p !== 1'b1) $display("FAIL abort_next_poll got %b exp 1", p); else passes++;
    endtask
`else
    task automatic test_analog_poll();
        logic a, p; logic [7:0] r;
        int acks, polls;
        logic [7:0] exp_r [11];
        exp_r = '{8'h73, 8'h5A, 8'hFE, 8'hFF, 8'h44, 8'h33, 8'h22, 8'h11, 8'hFF, 8'hFF, 8'hFF};
        acks = 0; polls = 0;
        deselect();
        buttons = 16'hFFFE;
        sticks = 32'h11223344;
        for (int i = 0; i < 11; i++) begin
            send(i == 0 ? 8'h01 : (i == 1 ? 8'h42 : 8'h00), a, r, p);
            acks += int'(a); polls += int'(p);
            checks++; if (r !== exp_r[i]) $display("FAIL analog_reply[%0d] got %h exp %h", i, r, exp_r[i]); else passes++;
            if (i == 8) begin
                checks++; if (p !== 1'b1) $display("FAIL analog_poll_pos got %b exp 1", p); else passes++;
            end
        end
        checks++; if (acks !== 8) $display("FAIL analog_acks got %0d exp 8", acks); else passes++;
        checks++; if (polls !== 1) $display("FAIL analog_polls got %0d exp 1", polls); else passes++;
    endtask
`endif

    initial begin
        test_reset();
`ifndef PPB_PAD_ANALOG_EN
        test_digital_poll();
`endif
        test_wrong_address();
`ifndef PPB_PAD_ANALOG_EN
        test_snapshot();
        test_mid_deselect();
`else
        test_analog_poll();
`endif
        test_collision();
        test_underrun();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
